// File: rtl/ppc_pkg.sv
// Shared fetch-path types. Bit 0 in the big-endian numbering is the MSB,
// so PowerPC [0:63] maps onto [63:0] here.
package ppc_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [63:0] addr_t;
    typedef logic [60:0] dwaddr_t;

    localparam int unsigned INST_BYTES = 4;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular instruction buffer for the fetch queue: up to two pushes and one pop
// per cycle, flush empties it. Pointers wrap modulo DEPTH (need not be a power of 2).
module ifq_fifo
    import ppc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [1:0]                 pushNum,
    input  logic [63:0]                pushPc0,
    input  logic [31:0]                pushInst0,
    input  logic [63:0]                pushPc1,
    input  logic [31:0]                pushInst1,
    input  logic                       pop,
    output logic [63:0]                headPc,
    output logic [31:0]                headInst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    ifq_entry_t      mem [DEPTH];
    logic [PtrW-1:0] rdPtr;
    logic [PtrW-1:0] wrPtr;
    logic [PtrW-1:0] wrPtrPlus1;

    function automatic logic [PtrW-1:0] ptrInc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wrPtrPlus1 = ptrInc(wrPtr);
    assign headPc     = mem[rdPtr].pc;
    assign headInst   = mem[rdPtr].inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                rdPtr <= ptrInc(rdPtr);
            end
            if (pushNum == 2'd2) begin
                wrPtr <= ptrInc(wrPtrPlus1);
            end else if (pushNum == 2'd1) begin
                wrPtr <= wrPtrPlus1;
            end
            count <= count + CntW'(pushNum) - CntW'(pop);
        end
    end

    // Storage needs no reset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (!flush && pushNum != 2'd0) begin
            mem[wrPtr] <= '{pc: pushPc0, inst: pushInst0};
        end
        if (!flush && pushNum == 2'd2) begin
            mem[wrPtrPlus1] <= '{pc: pushPc1, inst: pushInst1};
        end
    end

    overflowCheck: assert property (@(posedge clk) disable iff (rst)
        !flush |-> (int'(count) + int'(pushNum) - int'(pop) <= int'(DEPTH)));

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: one doubleword read in flight, redirect flushes everything.
// Optional macro IFQ_BYPASS_EN presents a response to decode in its arrival cycle.
module ifetch_queue
    import ppc_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_rd_en,
    output logic [60:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    addr_t           fetchPc;
    addr_t           reqPc;
    logic            pending;
    logic [CntW-1:0] count;
    logic [5:0]      needed;
    logic            fifoEmpty;
    logic            respValid;
    logic            respTwo;
    inst_t           respInst0;
    inst_t           respInst1;
    addr_t           respPc1;
    logic            bypass;
    logic            headValid;
    logic            take;
    logic            fifoPop;
    logic [1:0]      pushNum;
    addr_t           pushPc0;
    inst_t           pushInst0;
    addr_t           headPc;
    inst_t           headInst;
    logic            unusedLow;

    assign unusedLow = ^redirect_pc[1:0];

    // Space is reserved for the in-flight response as a full doubleword, and
    // judged on occupancy before any same-cycle pop.
    assign needed      = 6'(count) + (pending ? 6'd4 : 6'd2);
    assign mem_rd_en   = !rst && !redirect_valid && (needed <= 6'(DEPTH));
    assign mem_rd_addr = fetchPc[63:3];

    assign fifoEmpty = (count == '0);
    assign respValid = pending && !redirect_valid;
    assign respTwo   = !reqPc[2];
    assign respInst0 = reqPc[2] ? mem_rd_data[31:0] : mem_rd_data[63:32];
    assign respInst1 = mem_rd_data[31:0];
    assign respPc1   = reqPc + 64'(INST_BYTES);

`ifdef IFQ_BYPASS_EN
    assign bypass = fifoEmpty && respValid;
`else
    assign bypass = 1'b0;
`endif

    assign headValid  = !fifoEmpty || bypass;
    assign inst_valid = headValid;
    assign take       = headValid && inst_ready && !redirect_valid;
    assign fifoPop    = take && !bypass;

    always_comb begin
        inst    = '0;
        inst_pc = '0;
        if (bypass) begin
            inst    = respInst0;
            inst_pc = reqPc;
        end else if (headValid) begin
            inst    = headInst;
            inst_pc = headPc;
        end
    end

    always_comb begin
        pushNum   = 2'd0;
        pushPc0   = reqPc;
        pushInst0 = respInst0;
        if (respValid) begin
            if (bypass && take) begin
                // First word went straight to decode; only the second is stored.
                pushNum   = respTwo ? 2'd1 : 2'd0;
                pushPc0   = respPc1;
                pushInst0 = respInst1;
            end else begin
                pushNum = respTwo ? 2'd2 : 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc <= '0;
            reqPc   <= '0;
            pending <= 1'b0;
        end else begin
            pending <= mem_rd_en;
            if (mem_rd_en) begin
                reqPc <= fetchPc;
            end
            if (redirect_valid) begin
                fetchPc <= {redirect_pc[63:2], 2'b00};
            end else if (mem_rd_en) begin
                fetchPc <= {fetchPc[63:3] + 61'd1, 3'b000};
            end
        end
    end

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .pushNum  (pushNum),
        .pushPc0  (pushPc0),
        .pushInst0(pushInst0),
        .pushPc1  (respPc1),
        .pushInst1(respInst1),
        .pop      (fifoPop),
        .headPc   (headPc),
        .headInst (headInst),
        .count    (count)
    );

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue capacity in instructions; legal values are even numbers from 2 to 16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port redirect_valid, input, 1, which replaces the fetch PC (branch, or sc/halt restart).
REQ-005 SHALL have port redirect_pc, input, 64, the new fetch address, big-endian bit numbering [0:63].
REQ-006 SHALL have port mem_rd_en, output, 1, the doubleword read request to the memory fetch port.
REQ-007 SHALL have port mem_rd_addr, output, 61, the doubleword address, equal to fetch_pc[0:60].
REQ-008 SHALL have port mem_rd_data, input, 64, read data, valid exactly one cycle after mem_rd_en.
REQ-009 SHALL have port inst_valid, output, 1, meaning the queue head is presented to decode.
REQ-010 SHALL have port inst, output, 32, the head instruction word [0:31].
REQ-011 SHALL have port inst_pc, output, 64, the address of the head instruction.
REQ-012 SHALL have port inst_ready, input, 1; decode consumes the head when inst_valid and inst_ready are both high.

Function
REQ-013 SHALL hold an internal fetch_pc, bits [62:63] always 0, and a pending flag marking one read in flight.
REQ-014 SHALL assert mem_rd_en when redirect_valid=0 and count + 2*pending + 2 <= DEPTH, where count is the queue occupancy before this cycle's pop; a same-cycle pop SHALL NOT free space early.
REQ-015 SHALL add a returning doubleword in pc[61] order: if the request's fetch_pc[61]=0, push [0:31] at fetch_pc and then [32:63] at fetch_pc+4; if 1, push only [32:63] at fetch_pc.
REQ-016 SHALL set fetch_pc to {fetch_pc[0:60]+1, 3'b000} on each issued request; address arithmetic is modulo 2^64, so 0xFFFF_FFFF_FFFF_FFF8 wraps to 0.
REQ-017 SHALL pop the head on inst_valid & inst_ready; when empty, inst_valid SHALL be 0 and inst_ready SHALL be ignored.
REQ-018 SHALL, on redirect_valid, empty the queue in that cycle and drop the response to any in-flight request.
REQ-019 SHALL, on redirect_valid, load fetch_pc with {redirect_pc[0:61], 2'b00}, ignoring the low two bits.
REQ-020 SHALL issue no request in the redirect cycle and SHALL issue the first post-redirect request in the next cycle.
REQ-021 SHALL give redirect priority over a same-cycle pop and a same-cycle response; neither SHALL be observable afterwards.
REQ-022 SHALL never overflow; a push into a full queue is a design error, flagged by an assertion in simulation.
REQ-023 SHALL use at most one outstanding request; pending sets on mem_rd_en and clears on the following cycle.

Reset
REQ-024 SHALL, while rst=1, force fetch_pc=0, pending=0, count=0, mem_rd_en=0, mem_rd_addr=0, inst_valid=0, inst=0 and inst_pc=0.
REQ-025 SHALL issue the first request (address 0) in the first clk cycle after rst deasserts.
REQ-026 SHALL discard any response whose request preceded a reset asserted mid-operation.

Configuration
REQ-027 SHALL support macro IFQ_BYPASS_EN.
- Defined: a response arriving while the queue is empty is presented on inst/inst_pc/inst_valid in the same cycle (combinational bypass), and is consumed without being stored if inst_ready=1.
- Undefined: a response is visible no earlier than the cycle after it arrives.

Structure
REQ-028 SHALL take from shared package ppc_pkg:
- typedefs inst_t (32 bits), addr_t (64 bits) and dwaddr_t (61 bits);
- constant INST_BYTES=4.
REQ-029 SHALL place storage in one sub-module, ifq_fifo: a circular buffer of {addr_t, inst_t} entries with push, pop, flush, count, and pointers that wrap modulo DEPTH.

Verification
REQ-030 SHALL cover reset release with mem_rd_data[0:63]=0x38600001_44000002 returned for address 0 and inst_ready=1: inst 0x38600001 at pc 0, then inst 0x44000002 at pc 4.
REQ-031 SHALL cover redirect_pc=0x104: one push only, inst=mem_rd_data[32:63] with inst_pc=0x104, and the next mem_rd_addr=0x21 (byte 0x108).
REQ-032 SHALL cover DEPTH=4 with inst_ready=0: mem_rd_en stops after 2 requests, count stays 4, and no request is issued until a pop occurs.
REQ-033 SHALL cover redirect to 0x200 asserted in the cycle a response for 0x40 returns: the 0x40 words never appear, and the first inst_pc=0x200.
REQ-034 SHALL cover rst pulsed mid-fetch with one request pending: all outputs read 0 and the next request address is 0.
REQ-035 SHALL cover IFQ_BYPASS_EN defined with an empty queue: inst_valid rises in the response cycle; undefined, it rises one cycle later.
